// File: rtl/cache_ctrl_2way.sv
// 2-way set-associative, write-back, write-allocate cache controller with a word-serial memory port.
// Optional feature macro: CACHE_STATS_EN enables saturating hit/miss counters (tied to 0 otherwise).
module cache_ctrl_2way #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned SETS   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpuReq,
    input  logic              isRead,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              cpuReady,
    output logic              isHit,
    output logic              memReq,
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWriteData,
    input  logic [DATA_W-1:0] memReadData,
    input  logic              memAck,
    output logic [15:0]       hitCount,
    output logic [15:0]       missCount
);
    localparam int unsigned WORD_W = $clog2(WORDS);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - WORD_W - 2;
    localparam int unsigned CNT_W  = 16;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} stateT;

    stateT state;

    logic [DATA_W-1:0] dataArr [2][SETS][WORDS];
    logic [TAG_W-1:0]  tagArr  [2][SETS];
    logic [SETS-1:0]   validArr [2];
    logic [SETS-1:0]   dirtyArr [2];
    logic [SETS-1:0]   lru;

    logic              reqRead;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqData;
    logic              missFlag;
    logic              victimWay;
    logic [TAG_W-1:0]  victimTag;
    logic [WORD_W-1:0] beat;

    logic [IDX_W-1:0]  reqIdx;
    logic [TAG_W-1:0]  reqTag;
    logic [WORD_W-1:0] reqWord;
    logic [WORD_W-1:0] beatNext;
    logic              victimSel;
    logic              allocDone;

    assign reqIdx    = reqAddr[2+WORD_W +: IDX_W];
    assign reqTag    = reqAddr[ADDR_W-1 -: TAG_W];
    assign reqWord   = reqAddr[2 +: WORD_W];
    assign beatNext  = beat + WORD_W'(1);
    assign allocDone = (state == ALLOCATE) && memAck && (beat == LAST_BEAT);

    // Lookup looks at the incoming request in IDLE so a hit can complete in the COMPARE cycle.
    logic [ADDR_W-1:0] lookAddr;
    logic [IDX_W-1:0]  lookIdx;
    logic [TAG_W-1:0]  lookTag;
    logic [WORD_W-1:0] lookWord;
    logic              hit0;
    logic              hit1;
    logic              lookHit;
    logic              lookWay;
    logic              unusedLookBits;

    assign lookAddr       = (state == IDLE) ? address : reqAddr;
    assign lookIdx        = lookAddr[2+WORD_W +: IDX_W];
    assign lookTag        = lookAddr[ADDR_W-1 -: TAG_W];
    assign lookWord       = lookAddr[2 +: WORD_W];
    assign hit0           = validArr[0][lookIdx] && (tagArr[0][lookIdx] == lookTag);
    assign hit1           = validArr[1][lookIdx] && (tagArr[1][lookIdx] == lookTag);
    assign lookHit        = hit0 || hit1;
    assign lookWay        = hit1;
    assign unusedLookBits = ^lookAddr[1:0];

    // Victim: first invalid way, otherwise the least recently used one.
    assign victimSel = !validArr[0][reqIdx] ? 1'b0 :
                       !validArr[1][reqIdx] ? 1'b1 : lru[reqIdx];

    logic              dataWe;
    logic              dataWay;
    logic [WORD_W-1:0] dataWord;
    logic [DATA_W-1:0] dataWdata;

    always_comb begin
        dataWe    = 1'b0;
        dataWay   = lookWay;
        dataWord  = reqWord;
        dataWdata = reqData;
        if (!rst) begin
            if ((state == COMPARE) && lookHit && !reqRead) begin
                dataWe = 1'b1;
            end else if ((state == ALLOCATE) && memAck) begin
                dataWe    = 1'b1;
                dataWay   = victimWay;
                dataWord  = beat;
                dataWdata = memReadData;
            end
        end
    end

    // Data and tag storage carry no reset; valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (dataWe) begin
            dataArr[dataWay][reqIdx][dataWord] <= dataWdata;
        end
        if (!rst && allocDone) begin
            tagArr[victimWay][reqIdx] <= reqTag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            validArr     <= '{default: '0};
            dirtyArr     <= '{default: '0};
            lru          <= '0;
            reqRead      <= 1'b0;
            reqAddr      <= '0;
            reqData      <= '0;
            missFlag     <= 1'b0;
            victimWay    <= 1'b0;
            victimTag    <= '0;
            beat         <= '0;
            readData     <= '0;
            cpuReady     <= 1'b0;
            isHit        <= 1'b0;
            memReq       <= 1'b0;
            memWrite     <= 1'b0;
            memAddr      <= '0;
            memWriteData <= '0;
        end else begin
            cpuReady <= 1'b0;
            isHit    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpuReq) begin
                        reqRead  <= isRead;
                        reqAddr  <= address;
                        reqData  <= writeData;
                        missFlag <= 1'b0;
                        state    <= COMPARE;
                        if (lookHit) begin
                            cpuReady <= 1'b1;
                            isHit    <= 1'b1;
                            if (isRead) begin
                                readData <= dataArr[lookWay][lookIdx][lookWord];
                            end
                        end
                    end
                end
                COMPARE: begin
                    if (lookHit) begin
                        if (!reqRead) begin
                            dirtyArr[lookWay][reqIdx] <= 1'b1;
                        end
                        lru[reqIdx] <= ~lookWay;
                        state       <= IDLE;
                    end else begin
                        missFlag  <= 1'b1;
                        victimWay <= victimSel;
                        victimTag <= tagArr[victimSel][reqIdx];
                        beat      <= '0;
                        memReq    <= 1'b1;
                        if (validArr[victimSel][reqIdx] && dirtyArr[victimSel][reqIdx]) begin
                            state        <= WRITEBACK;
                            memWrite     <= 1'b1;
                            memAddr      <= {tagArr[victimSel][reqIdx], reqIdx, WORD_W'(0), 2'b00};
                            memWriteData <= dataArr[victimSel][reqIdx][0];
                        end else begin
                            state    <= ALLOCATE;
                            memWrite <= 1'b0;
                            memAddr  <= {reqTag, reqIdx, WORD_W'(0), 2'b00};
                        end
                    end
                end
                WRITEBACK: begin
                    if (memAck) begin
                        if (beat == LAST_BEAT) begin
                            dirtyArr[victimWay][reqIdx] <= 1'b0;
                            state    <= ALLOCATE;
                            beat     <= '0;
                            memWrite <= 1'b0;
                            memAddr  <= {reqTag, reqIdx, WORD_W'(0), 2'b00};
                        end else begin
                            beat         <= beatNext;
                            memAddr      <= {victimTag, reqIdx, beatNext, 2'b00};
                            memWriteData <= dataArr[victimWay][reqIdx][beatNext];
                        end
                    end
                end
                ALLOCATE: begin
                    if (memAck) begin
                        if (beat == LAST_BEAT) begin
                            validArr[victimWay][reqIdx] <= 1'b1;
                            dirtyArr[victimWay][reqIdx] <= 1'b0;
                            memReq   <= 1'b0;
                            state    <= COMPARE;
                            cpuReady <= 1'b1;
                            isHit    <= !missFlag;
                            // The requested word may be arriving on this very beat.
                            if (reqRead) begin
                                readData <= (reqWord == beat) ? memReadData
                                                              : dataArr[victimWay][reqIdx][reqWord];
                            end
                        end else begin
                            beat    <= beatNext;
                            memAddr <= {reqTag, reqIdx, beatNext, 2'b00};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hitCount  <= '0;
            missCount <= '0;
        end else if (cpuReady) begin
            if (isHit) begin
                if (hitCount != {CNT_W{1'b1}}) hitCount <= hitCount + CNT_W'(1);
            end else begin
                if (missCount != {CNT_W{1'b1}}) missCount <= missCount + CNT_W'(1);
            end
        end
    end
`else
    assign hitCount  = '0;
    assign missCount = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Self-checking bench for cache_ctrl_2way: directed test-plan scenarios, then random
// accesses against a set/way/LRU reference model and a word-addressed memory image.
module tb_cache_ctrl_2way;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpuReq;
    logic        isRead;
    logic [9:0]  address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        cpuReady;
    logic        isHit;
    logic        memReq;
    logic        memWrite;
    logic [9:0]  memAddr;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        memAck;
    logic [15:0] hitCount;
    logic [15:0] missCount;

    cache_ctrl_2way dut (
        .clk(clk), .rst(rst), .cpuReq(cpuReq), .isRead(isRead), .address(address),
        .writeData(writeData), .readData(readData), .cpuReady(cpuReady), .isHit(isHit),
        .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memWriteData(memWriteData),
        .memReadData(memReadData), .memAck(memAck), .hitCount(hitCount), .missCount(missCount)
    );

    typedef struct packed {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
    } beatT;

    function automatic logic [31:0] memPreset(input int i);
        case (i)
            0:       return 32'h0000_3cc3;
            'h80:    return 32'h0000_0ccc;
            'hC0:    return 32'h0000_00c3;
            default: return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
        endcase
    endfunction

    // Memory responder: serves read beats, absorbs write beats, logs every acknowledged beat.
    logic [31:0] mem [256];
    beatT        obsQ[$];
    int          stallCnt = 0;
    int          beatsDone = 0;
    int          stallAddrErr = 0;
    bit          memInit = 1'b0;
    bit          prevStall = 1'b0;
    logic [9:0]  prevAddr = '0;
    logic        prevWr = 1'b0;

    assign memReadData = mem[memAddr[9:2]];

    always @(posedge clk) begin
        if (!memInit) begin
            for (int i = 0; i < 256; i++) mem[i] <= memPreset(i);
            memInit = 1'b1;
        end
        if (!rst && memReq) begin
            if (prevStall && (memAddr != prevAddr || memWrite != prevWr)) stallAddrErr++;
            if (memAck) begin
                obsQ.push_back({memWrite, memAddr, memWriteData});
                if (memWrite) mem[memAddr[9:2]] <= memWriteData;
                beatsDone++;
            end else begin
                stallCnt++;
            end
            prevStall = !memAck;
            prevAddr  = memAddr;
            prevWr    = memWrite;
        end else begin
            beatsDone = 0;
            prevStall = 1'b0;
        end
    end

    // Reference model: whole-cache state as plain arrays, addresses decomposed arithmetically.
    bit          refValid [2][4];
    bit          refDirty [2][4];
    int          refTag   [2][4];
    int          refLru   [4];
    logic [31:0] refData  [2][4][4];
    logic [31:0] refMem   [256];
    int          refHits;
    int          refMisses;
    beatT        expQ[$];

    int checkCnt = 0;
    int passCnt  = 0;
    int ackPct   = 100;
    int lastLat;
    int lastStalls;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else passCnt++;
    endtask

    task automatic modelReset();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 4; s++) begin
                refValid[w][s] = 1'b0;
                refDirty[w][s] = 1'b0;
            end
        for (int s = 0; s < 4; s++) refLru[s] = 0;
        refHits   = 0;
        refMisses = 0;
    endtask

    task automatic modelAccess(input logic rd, input logic [9:0] a, input logic [31:0] wd,
                               output logic hit, output logic [31:0] rdata, output int wb);
        int ai, s, w, t, way, ba;
        ai = int'(a);
        s = (ai / 16) % 4;
        w = (ai / 4) % 4;
        t = ai / 64;
        hit = 1'b0; rdata = '0; wb = 0; way = 0;
        for (int k = 0; k < 2; k++)
            if (refValid[k][s] && refTag[k][s] == t) begin hit = 1'b1; way = k; end
        if (!hit) begin
            if (!refValid[0][s]) way = 0;
            else if (!refValid[1][s]) way = 1;
            else way = refLru[s];
            if (refValid[way][s] && refDirty[way][s]) begin
                for (int b = 0; b < 4; b++) begin
                    ba = refTag[way][s] * 64 + s * 16 + b * 4;
                    expQ.push_back({1'b1, 10'(ba), refData[way][s][b]});
                    refMem[ba / 4] = refData[way][s][b];
                end
                wb = 4;
            end
            for (int b = 0; b < 4; b++) begin
                ba = t * 64 + s * 16 + b * 4;
                expQ.push_back({1'b0, 10'(ba), 32'h0});
                refData[way][s][b] = refMem[ba / 4];
            end
            refValid[way][s] = 1'b1;
            refDirty[way][s] = 1'b0;
            refTag[way][s]   = t;
            refMisses++;
        end else begin
            refHits++;
        end
        if (rd) rdata = refData[way][s][w];
        else begin
            refData[way][s][w] = wd;
            refDirty[way][s]   = 1'b1;
        end
        refLru[s] = 1 - way;
    endtask

    // One CPU access with latency, hit flag, load data and memory-beat sequence checks.
    task automatic doAccess(input logic rd, input logic [9:0] a, input logic [31:0] wd, input int stallReq);
        logic        expHit;
        logic [31:0] expData;
        int          wb, obs0, stall0, expLat, nObs, stallLeft;
        bit          done;
        expQ.delete();
        modelAccess(rd, a, wd, expHit, expData, wb);
        stallLeft = stallReq;
        @(negedge clk);
        cpuReq = 1'b1; isRead = rd; address = a; writeData = wd;
        obs0 = obsQ.size(); stall0 = stallCnt;
        lastLat = 0; done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            lastLat++;
            if (cpuReady) begin
                done = 1'b1;
                cpuReq = 1'b0;
            end else begin
                cpuReq    = 1'($urandom);
                isRead    = 1'($urandom);
                address   = 10'($urandom);
                writeData = $urandom;
                if (stallLeft > 0 && memReq && (beatsDone % 4) == 1) begin
                    memAck = 1'b0;
                    stallLeft--;
                end else begin
                    memAck = ($urandom_range(99) < ackPct);
                end
            end
        end
        memAck = 1'b1;
        if (!done) begin
            checkVal("cpuReadyTimeout", 32'd0, 32'd1);
            return;
        end
        lastStalls = stallCnt - stall0;
        expLat = expHit ? 1 : 6 + wb + lastStalls;
        checkVal("isHit", 32'(isHit), 32'(expHit));
        checkVal("latency", 32'(lastLat), 32'(expLat));
        if (rd) checkVal("readData", readData, expData);
        nObs = obsQ.size() - obs0;
        checkVal("beatCount", 32'(nObs), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < nObs; i++) begin
            checkVal($sformatf("beat%0dWrite", i), 32'(obsQ[obs0 + i].wr), 32'(expQ[i].wr));
            checkVal($sformatf("beat%0dAddr", i), 32'(obsQ[obs0 + i].addr), 32'(expQ[i].addr));
            if (expQ[i].wr) checkVal($sformatf("beat%0dData", i), obsQ[obs0 + i].data, expQ[i].data);
        end
    endtask

    initial begin
        bit found;
        logic [9:0] ra;
        rst = 1'b1; cpuReq = 1'b0; isRead = 1'b0; address = '0; writeData = '0; memAck = 1'b1;
        for (int i = 0; i < 256; i++) refMem[i] = memPreset(i);
        modelReset();
        repeat (3) @(negedge clk);
        checkVal("rstReadData", readData, 32'h0);
        checkVal("rstCpuReady", 32'(cpuReady), 32'h0);
        checkVal("rstIsHit", 32'(isHit), 32'h0);
        checkVal("rstMemReq", 32'(memReq), 32'h0);
        checkVal("rstMemWrite", 32'(memWrite), 32'h0);
        checkVal("rstMemAddr", 32'(memAddr), 32'h0);
        checkVal("rstMemWriteData", memWriteData, 32'h0);
        checkVal("rstHitCount", 32'(hitCount), 32'h0);
        checkVal("rstMissCount", 32'(missCount), 32'h0);
        rst = 1'b0;

        // Directed scenarios with memAck tied high.
        doAccess(1'b1, 10'h000, 32'h0, 0);
        checkVal("coldMissLatency", 32'(lastLat), 32'd6);
        doAccess(1'b0, 10'h000, 32'h0000_00ff, 0);
        doAccess(1'b1, 10'h000, 32'h0, 0);
        checkVal("memWord0Unchanged", mem[0], 32'h0000_3cc3);
        doAccess(1'b1, 10'h200, 32'h0, 0);
        doAccess(1'b1, 10'h000, 32'h0, 0);
        doAccess(1'b1, 10'h300, 32'h0, 0);
        doAccess(1'b1, 10'h200, 32'h0, 0);
        checkVal("dirtyEvictLatency", 32'(lastLat), 32'd10);
        checkVal("memWord0WrittenBack", mem[0], 32'h0000_00ff);
        doAccess(1'b1, 10'h040, 32'h0, 3);
        checkVal("stallCycles", 32'(lastStalls), 32'd3);
        checkVal("stalledLatency", 32'(lastLat), 32'd9);

        // Reset while the refill is on beat 2.
        @(negedge clk);
        cpuReq = 1'b1; isRead = 1'b1; address = 10'h030;
        @(negedge clk);
        cpuReq = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            if (memReq && !memWrite && beatsDone == 2) found = 1'b1;
            else @(negedge clk);
        end
        checkVal("reachAllocBeat2", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkVal("midRstMemReq", 32'(memReq), 32'h0);
        checkVal("midRstCpuReady", 32'(cpuReady), 32'h0);
        checkVal("midRstMemAddr", 32'(memAddr), 32'h0);
        rst = 1'b0;
        modelReset();
        doAccess(1'b1, 10'h000, 32'h0, 0);
        checkVal("missAfterRst", 32'(isHit), 32'h0);

        // Random traffic with memory stalls.
        ackPct = 70;
        for (int n = 0; n < 400; n++) begin
            ra = {4'($urandom_range(0, 3)), 2'($urandom), 2'($urandom), 2'($urandom)};
            doAccess(1'($urandom), ra, $urandom, 0);
        end
        ackPct = 100;
        repeat (3) @(negedge clk);

        checkVal("stallAddrStable", 32'(stallAddrErr), 32'd0);
`ifdef CACHE_STATS_EN
        checkVal("hitCount", 32'(hitCount), 32'(refHits > 65535 ? 65535 : refHits));
        checkVal("missCount", 32'(missCount), 32'(refMisses > 65535 ? 65535 : refMisses));
`else
        checkVal("hitCount", 32'(hitCount), 32'd0);
        checkVal("missCount", 32'(missCount), 32'd0);
`endif
        for (int i = 0; i < 256; i++) checkVal($sformatf("memWord%0d", i), mem[i], refMem[i]);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end
endmodule
